mux_stream: RTL and testbench

MUX_STREAM -- requirements
Module: mux_stream

---
 rtl/mux_stream_if.sv | 28 ++
 rtl/mux_stream.sv | 141 ++++++++++++++
 tb/tb_mux_stream.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/mux_stream_if.sv
// Stream bundle for mux_stream: flattened per-channel input data with
// per-channel valid/ready, plus the single registered output channel.
// The slave modport is the mux side; the master modport is the side that
// drives the channel inputs and consumes the output.
interface mux_stream_if #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4
);
  localparam int SEL_W = $clog2(CHANNELS);

  logic [WIDTH*CHANNELS-1:0] d;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic [WIDTH-1:0]          o;
  logic                      o_valid;
  logic                      o_ready;
  logic [SEL_W-1:0]          o_ch;

  modport master (
    output d, in_valid, o_ready,
    input  in_ready, o, o_valid, o_ch
  );

  modport slave (
    input  d, in_valid, o_ready,
    output in_ready, o, o_valid, o_ch
  );
endinterface

// File: rtl/mux_stream.sv
// mux_stream: N-channel stream multiplexer into a single output register.
// Fixed-select (mode_i=0, channel sel_i) or round-robin (mode_i=1) grant,
// at most one channel per cycle, full throughput when the output drains.
// Optional accepted-word counter enabled by defining MUX_STREAM_CNT_EN;
// without it cnt_o is tied to zero.
module mux_stream #(
  parameter int  WIDTH    = 32,
  parameter int  CHANNELS = 4,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode_i,
  input  logic [SEL_W-1:0]  sel_i,
  output logic [15:0]       cnt_o,
  mux_stream_if.slave       bus
);

  localparam logic [SEL_W:0]   CH_N     = (SEL_W+1)'(CHANNELS);
  localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(CHANNELS-1);

  logic [WIDTH-1:0]    ch_data [CHANNELS];
  logic [CHANNELS-1:0] in_ready_w;

  logic [WIDTH-1:0]    o_q, o_d;
  logic [SEL_W-1:0]    o_ch_q, o_ch_d;
  logic                o_valid_q, o_valid_d;
  logic [SEL_W-1:0]    ptr_q, ptr_d;

  logic                grant_any;
  logic [SEL_W-1:0]    grant_idx;
  logic [SEL_W:0]      cand;
  logic                can_accept;
  logic                xfer;

  genvar gi;

  // Unpack the flattened data bus and build the one-hot ready vector.
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      assign ch_data[gi]    = bus.d[gi*WIDTH +: WIDTH];
      assign in_ready_w[gi] = xfer && (grant_idx == SEL_W'(gi));
    end
  endgenerate

  // The output slot is free when empty or being drained this cycle.
  assign can_accept   = !o_valid_q || bus.o_ready;
  // Reset blocks transfers so that nothing is acknowledged and then dropped.
  assign xfer         = rst_n && grant_any && can_accept;
  assign bus.in_ready = in_ready_w;

  // Grant decision: fixed select, or first valid channel after the pointer.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    if (!mode_i) begin
      // Out-of-range selects (non power-of-two CHANNELS) grant nothing.
      if (({1'b0, sel_i} < CH_N) && bus.in_valid[sel_i]) begin
        grant_any = 1'b1;
        grant_idx = sel_i;
      end
    end else begin
      for (int i = 1; i <= CHANNELS; i++) begin
        cand = {1'b0, ptr_q} + (SEL_W+1)'(i);
        if (cand >= CH_N) begin
          cand = cand - CH_N;
        end
        if (!grant_any && bus.in_valid[cand[SEL_W-1:0]]) begin
          grant_any = 1'b1;
          grant_idx = cand[SEL_W-1:0];
        end
      end
    end
  end

  // Next state of the output register and round-robin pointer.
  always_comb begin
    o_d       = o_q;
    o_ch_d    = o_ch_q;
    o_valid_d = o_valid_q;
    ptr_d     = ptr_q;
    if (xfer) begin
      o_d       = ch_data[grant_idx];
      o_ch_d    = grant_idx;
      o_valid_d = 1'b1;
      // The pointer only tracks round-robin grants; fixed mode leaves it alone.
      if (mode_i) begin
        ptr_d = grant_idx;
      end
    end else if (bus.o_ready) begin
      // Drained with nothing to replace it: data and channel keep last value.
      o_valid_d = 1'b0;
    end
  end

  // Output register and pointer; reset leaves channel 0 first in line.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_q       <= '0;
      o_ch_q    <= '0;
      o_valid_q <= 1'b0;
      ptr_q     <= LAST_CH;
    end else begin
      o_q       <= o_d;
      o_ch_q    <= o_ch_d;
      o_valid_q <= o_valid_d;
      ptr_q     <= ptr_d;
    end
  end

  assign bus.o       = o_q;
  assign bus.o_ch    = o_ch_q;
  assign bus.o_valid = o_valid_q;

`ifdef MUX_STREAM_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  // Counts accepted input words, wrapping naturally at 16 bits.
  always_comb begin
    cnt_d = cnt_q;
    if (xfer) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Counter register, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
`else
  assign cnt_o = '0;
`endif

endmodule

// File: tb/tb_mux_stream.sv
// Self-checking bench for mux_stream (WIDTH=32, CHANNELS=4): directed vectors,
// a cycle-level behavioural model, and literal expectations for key scenarios.
module tb_mux_stream;
  localparam int W  = 32;
  localparam int CH = 4;
`ifdef MUX_STREAM_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mode;
  logic [1:0]  s;
  logic [15:0] cnt;
  logic [W-1:0] chd [CH];

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;
  bit quiet = 1'b0;

  // Behavioural model state
  bit          m_valid;
  logic [W-1:0] m_o;
  int          m_ch;
  int          m_ptr;
  int          m_cnt;

  mux_stream_if #(.WIDTH(W), .CHANNELS(CH)) bus ();

  mux_stream #(.WIDTH(W), .CHANNELS(CH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mode_i(mode),
    .sel_i (s),
    .cnt_o (cnt),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.d = {chd[3], chd[2], chd[1], chd[0]};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Which channel the rules grant right now (-1 = none).
  function automatic int model_grant();
    if (!mode) begin
      if (int'(s) < CH && bus.in_valid[s]) return int'(s);
      return -1;
    end
    for (int k = 1; k <= CH; k++) begin
      int c;
      c = (m_ptr + k) % CH;
      if (bus.in_valid[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [3:0] model_ready();
    int g;
    g = model_grant();
    if (rst_n && (!m_valid || bus.o_ready) && g >= 0) return 4'(1 << g);
    return 4'b0000;
  endfunction

  // Model update on each rising edge from the inputs present before it.
  always @(posedge clk) begin
    int g;
    if (!rst_n) begin
      started = 1'b1;
      m_valid = 1'b0; m_o = '0; m_ch = 0; m_ptr = CH - 1; m_cnt = 0;
    end else if (started) begin
      g = model_grant();
      if (g >= 0 && (!m_valid || bus.o_ready)) begin
        m_o = chd[g]; m_ch = g; m_valid = 1'b1;
        if (mode) m_ptr = g;
        if (CNT_ON) m_cnt = (m_cnt + 1) % 65536;
        if (!quiet) $display("xfer t=%0t ch=%0d data=%h cnt=%0d", $time, g, chd[g], m_cnt);
      end else if (bus.o_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin
    if (started) begin
      chk("cmp_o_valid", 32'(bus.o_valid), 32'(m_valid));
      chk("cmp_o", bus.o, m_o);
      chk("cmp_o_ch", 32'(bus.o_ch), 32'(m_ch));
      chk("cmp_in_ready", 32'(bus.in_ready), 32'(model_ready()));
      chk("cmp_cnt", 32'(cnt), 32'(m_cnt));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  typedef struct { bit md; logic [1:0] sl; logic [3:0] vl; bit rdy; } vec_t;
  vec_t tbl [12];

  initial begin
    rst_n = 1'b0; mode = 1'b0; s = 2'd0; bus.in_valid = 4'hF; bus.o_ready = 1'b1;
    for (int k = 0; k < CH; k++) chd[k] = 32'hA000_0000 + 32'(k);
    tick(); tick();
    // Reset state, ready held low during reset even with valids high
    chk("rst_in_ready", 32'(bus.in_ready), 32'h0);
    chk("rst_o_valid", 32'(bus.o_valid), 32'h0);
    chk("rst_o", bus.o, 32'h0);
    chk("rst_o_ch", 32'(bus.o_ch), 32'h0);
    chk("rst_cnt", 32'(cnt), 32'h0);

    // Fixed select channel 2
    rst_n = 1'b1; mode = 1'b0; s = 2'd2; chd[2] = 32'h6;
    #1 chk("fix_in_ready", 32'(bus.in_ready), 32'b0100);
    tick();
    chk("fix_o", bus.o, 32'h6);
    chk("fix_o_ch", 32'(bus.o_ch), 32'd2);
    chk("fix_o_valid", 32'(bus.o_valid), 32'd1);

    // Fixed select of an idle channel: output drains, data holds
    s = 2'd1; bus.in_valid = 4'b1101;
    #1 chk("fix_idle_ready", 32'(bus.in_ready), 32'h0);
    tick();
    chk("drain_o_valid", 32'(bus.o_valid), 32'd0);
    chk("drain_o_hold", bus.o, 32'h6);

    // Round-robin from reset: 0,1,2,3,0 back to back
    rst_n = 1'b0; tick();
    rst_n = 1'b1; mode = 1'b1; bus.in_valid = 4'hF;
    chd[0] = 32'h0000_1000; chd[1] = 32'h0000_1001; chd[2] = 32'h0000_1002; chd[3] = 32'h3333_0003;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rr_o_ch", 32'(bus.o_ch), 32'(i % 4));
      chk("rr_o_valid", 32'(bus.o_valid), 32'd1);
    end
    chk("rr_cnt5", 32'(cnt), CNT_ON ? 32'd5 : 32'd0);

    // One-cycle reset while a word is held
    rst_n = 1'b0; tick();
    chk("mid_rst_o_valid", 32'(bus.o_valid), 32'd0);
    chk("mid_rst_cnt", 32'(cnt), 32'd0);
    rst_n = 1'b1; tick();
    chk("post_rst_o_ch", 32'(bus.o_ch), 32'd0);
    chk("post_rst_o", bus.o, 32'h0000_1000);

    // Round-robin with only channels 1 and 3 valid
    rst_n = 1'b0; tick();
    rst_n = 1'b1; bus.in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      #1 chk("rr13_in_ready", 32'(bus.in_ready), (i % 2 == 0) ? 32'b0010 : 32'b1000);
      tick();
      chk("rr13_o_ch", 32'(bus.o_ch), (i % 2 == 0) ? 32'd1 : 32'd3);
    end
    chk("model_pin_ch", 32'(m_ch), 32'd3);

    // Backpressure: hold for 3 cycles then load on release
    bus.o_ready = 1'b0; chd[1] = 32'h0000_0011;
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_in_ready", 32'(bus.in_ready), 32'h0);
      tick();
      chk("bp_o_hold", bus.o, 32'h3333_0003);
      chk("bp_o_ch", 32'(bus.o_ch), 32'd3);
      chk("bp_o_valid", 32'(bus.o_valid), 32'd1);
    end
    bus.o_ready = 1'b1;
    #1 chk("bp_release_ready", 32'(bus.in_ready), 32'b0010);
    tick();
    chk("bp_new_o", bus.o, 32'h0000_0011);
    chk("bp_new_ch", 32'(bus.o_ch), 32'd1);
    chk("model_pin_o", m_o, 32'h0000_0011);

    bus.in_valid = 4'b0000; tick();
    chk("idle_o_valid", 32'(bus.o_valid), 32'd0);
    chk("idle_o_hold", bus.o, 32'h0000_0011);

    // Mixed directed table, checked by the model each cycle
    tbl[0]  = '{1'b1, 2'd0, 4'b0110, 1'b1};
    tbl[1]  = '{1'b1, 2'd0, 4'b0110, 1'b0};
    tbl[2]  = '{1'b0, 2'd3, 4'b1000, 1'b0};
    tbl[3]  = '{1'b0, 2'd3, 4'b1000, 1'b1};
    tbl[4]  = '{1'b0, 2'd0, 4'b1110, 1'b1};
    tbl[5]  = '{1'b1, 2'd0, 4'b0001, 1'b1};
    tbl[6]  = '{1'b1, 2'd2, 4'b1001, 1'b1};
    tbl[7]  = '{1'b1, 2'd2, 4'b1001, 1'b1};
    tbl[8]  = '{1'b0, 2'd1, 4'b0010, 1'b0};
    tbl[9]  = '{1'b1, 2'd1, 4'b1111, 1'b0};
    tbl[10] = '{1'b1, 2'd1, 4'b1111, 1'b1};
    tbl[11] = '{1'b0, 2'd2, 4'b0000, 1'b1};
    for (int i = 0; i < 12; i++) begin
      mode = tbl[i].md; s = tbl[i].sl; bus.in_valid = tbl[i].vl; bus.o_ready = tbl[i].rdy;
      for (int k = 0; k < CH; k++) chd[k] = 32'(i * 16 + k);
      tick();
    end

    // Counter wrap: 65537 transfers
    rst_n = 1'b0; tick();
    rst_n = 1'b1; mode = 1'b1; bus.in_valid = 4'hF; bus.o_ready = 1'b1; quiet = 1'b1;
    repeat (65537) tick();
    bus.in_valid = 4'h0;
    chk("cnt_wrap", 32'(cnt), CNT_ON ? 32'd1 : 32'd0);
    quiet = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
